// File: rtl/scrambler_pkg.sv
// -----------------------------------------------------------------------------
// scrambler_pkg
// Shared constants and types for the 64b/66b self-synchronous scrambler
// (polynomial x^58 + x^39 + 1).
//   LFSR_LEN / TAP_A / TAP_B : register length and the two feedback taps
//   LFSR_DEFAULT_SEED        : all-ones state used when no seed is given
//   lfsr_t                   : 58-bit LFSR state
//   sync_hdr_t               : 2-bit 66b sync header, HDR_DATA / HDR_CTRL
// -----------------------------------------------------------------------------
package scrambler_pkg;

    localparam int LFSR_LEN = 58;
    localparam int TAP_A    = 38;
    localparam int TAP_B    = 57;

    typedef logic [LFSR_LEN-1:0] lfsr_t;

    localparam lfsr_t LFSR_DEFAULT_SEED = 58'h3FF_FFFF_FFFF_FFFF;

    typedef logic [1:0] sync_hdr_t;

    localparam sync_hdr_t HDR_DATA = 2'b01;
    localparam sync_hdr_t HDR_CTRL = 2'b10;

endpackage

// File: rtl/scrambler_core.sv
// -----------------------------------------------------------------------------
// scrambler_core
// Purely combinational, fully unrolled (de)scrambler for one payload beat.
//   data_in   : payload beat, bit 0 is the first bit on the line
//   state_in  : LFSR state before the beat
//   data_out  : (de)scrambled payload
//   state_out : LFSR state after all DATA_WIDTH bits
// The LFSR always shifts in the line-side bit: the scrambled output when
// scrambling, the received input when descrambling. That is what makes the
// descrambler self-synchronising.
// -----------------------------------------------------------------------------
module scrambler_core
    import scrambler_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter bit DESCRAMBLE = 1'b0
) (
    input  logic [DATA_WIDTH-1:0] data_in,
    input  lfsr_t                 state_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output lfsr_t                 state_out
);

    lfsr_t work_state;
    logic  out_bit;

    always_comb begin
        work_state = state_in;
        out_bit    = 1'b0;
        data_out   = '0;
        for (int k = 0; k < DATA_WIDTH; k++) begin
            out_bit     = data_in[k] ^ work_state[TAP_A] ^ work_state[TAP_B];
            data_out[k] = out_bit;
            work_state  = {work_state[LFSR_LEN-2:0], (DESCRAMBLE ? data_in[k] : out_bit)};
        end
        state_out = work_state;
    end

endmodule

// File: rtl/pcs_scrambler_ss.sv
// -----------------------------------------------------------------------------
// pcs_scrambler_ss
// Self-synchronous 64b/66b scrambler / descrambler with valid/ready flow
// control, one register stage of latency and full throughput. The sync header
// travels as sideband alongside its payload beat and is never scrambled.
//   i_clk, i_reset_n               : clock, asynchronous active-low reset
//   i_data_valid/o_data_ready      : upstream handshake
//   i_data, i_hdr, i_hdr_valid     : upstream payload and sideband header
//   o_data_valid/i_data_ready      : downstream handshake
//   o_data, o_hdr, o_hdr_valid     : registered (de)scrambled beat and header
//   i_seed_load                    : reload LFSR with LFSR_SEED
//   o_primed                       : LFSR holds valid line history
// -----------------------------------------------------------------------------
module pcs_scrambler_ss
    import scrambler_pkg::*;
#(
    parameter int    DATA_WIDTH       = 32,
    parameter bit    DESCRAMBLE       = 1'b0,
    parameter bit    SCRAMBLER_BYPASS = 1'b0,
    parameter lfsr_t LFSR_SEED        = LFSR_DEFAULT_SEED
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_data_valid,
    output logic                  o_data_ready,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  sync_hdr_t             i_hdr,
    input  logic                  i_hdr_valid,
    output logic                  o_data_valid,
    input  logic                  i_data_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output sync_hdr_t             o_hdr,
    output logic                  o_hdr_valid,
    input  logic                  i_seed_load,
    output logic                  o_primed
);

    generate
        if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
            $error("pcs_scrambler_ss: DATA_WIDTH must be 32 or 64");
        end
    endgenerate

    // Beats needed before the descrambler history covers all 58 taps.
    localparam int        PRIME_BEATS = (LFSR_LEN + DATA_WIDTH - 1) / DATA_WIDTH;
    localparam logic [1:0] PRIME_CNT  = 2'(PRIME_BEATS);

    logic                  in_xfer;
    logic                  out_xfer;
    lfsr_t                 lfsr_reg, lfsr_next;
    lfsr_t                 lfsr_base;
    lfsr_t                 core_state;
    logic [DATA_WIDTH-1:0] core_data;

    logic                  out_valid_reg, out_valid_next;
    logic [DATA_WIDTH-1:0] data_reg, data_next;
    sync_hdr_t             hdr_reg, hdr_next;
    logic                  hdr_valid_reg, hdr_valid_next;
    logic [1:0]            prime_cnt_reg, prime_cnt_next;
    logic                  primed_reg, primed_next;

    assign o_data_ready = ~out_valid_reg | i_data_ready;
    assign in_xfer      = i_data_valid & o_data_ready;
    assign out_xfer     = out_valid_reg & i_data_ready;

    // A seed load in the same cycle as a transfer processes that beat from
    // the seed, so the seed is muxed in ahead of the core.
    assign lfsr_base = i_seed_load ? LFSR_SEED : lfsr_reg;

    scrambler_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .DESCRAMBLE (DESCRAMBLE)
    ) u_core (
        .data_in   (i_data),
        .state_in  (lfsr_base),
        .data_out  (core_data),
        .state_out (core_state)
    );

    always_comb begin
        lfsr_next      = lfsr_reg;
        out_valid_next = out_valid_reg;
        data_next      = data_reg;
        hdr_next       = hdr_reg;
        hdr_valid_next = hdr_valid_reg;
        prime_cnt_next = prime_cnt_reg;
        primed_next    = primed_reg;

        if (in_xfer && !SCRAMBLER_BYPASS) begin
            lfsr_next = core_state;
        end else if (i_seed_load) begin
            lfsr_next = LFSR_SEED;
        end

        if (in_xfer) begin
            out_valid_next = 1'b1;
            data_next      = SCRAMBLER_BYPASS ? i_data : core_data;
            hdr_next       = i_hdr;
            hdr_valid_next = i_hdr_valid;
        end else if (out_xfer) begin
            out_valid_next = 1'b0;
        end

        if (DESCRAMBLE) begin
            if (i_seed_load) begin
                prime_cnt_next = in_xfer ? 2'd1 : 2'd0;
            end else if (in_xfer && prime_cnt_reg != PRIME_CNT) begin
                prime_cnt_next = prime_cnt_reg + 2'd1;
            end
            primed_next = (prime_cnt_next == PRIME_CNT);
        end else begin
            // A scrambler generates its own history, so it is primed as soon
            // as it leaves reset.
            primed_next = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            lfsr_reg      <= LFSR_SEED;
            out_valid_reg <= 1'b0;
            data_reg      <= '0;
            hdr_reg       <= '0;
            hdr_valid_reg <= 1'b0;
            prime_cnt_reg <= 2'd0;
            primed_reg    <= 1'b0;
        end else begin
            lfsr_reg      <= lfsr_next;
            out_valid_reg <= out_valid_next;
            data_reg      <= data_next;
            hdr_reg       <= hdr_next;
            hdr_valid_reg <= hdr_valid_next;
            prime_cnt_reg <= prime_cnt_next;
            primed_reg    <= primed_next;
        end
    end

    assign o_data_valid = out_valid_reg;
    assign o_data       = data_reg;
    assign o_hdr        = hdr_reg;
    assign o_hdr_valid  = hdr_valid_reg;
    assign o_primed     = primed_reg;

endmodule

// File: tb/tb_pcs_scrambler_ss.sv
// -----------------------------------------------------------------------------
// tb_pcs_scrambler_ss
// Four instances: a 32-bit scrambler (dut), a scrambler (tx2) chained into a
// descrambler seeded with zero (rx), and a bypass scrambler (byp). The dut is
// checked against a line-history model: each output bit is the input bit xor
// the line bits sent 39 and 58 positions earlier.
// -----------------------------------------------------------------------------
module tb_pcs_scrambler_ss;
    import scrambler_pkg::*;

    localparam lfsr_t SEED_ONES = 58'h3FF_FFFF_FFFF_FFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    int n_tests = 0;
    int n_fail  = 0;

    // dut
    logic d_ivalid, d_oready, d_ihvalid, d_ovalid, d_iready, d_ohvalid, d_seed, d_primed;
    logic [31:0] d_idata, d_odata;
    sync_hdr_t d_ihdr, d_ohdr;
    // tx2 -> rx chain
    logic t_ivalid, t_oready, t_ihvalid, t_ovalid, t_iready, t_ohvalid, t_seed, t_primed;
    logic [31:0] t_idata, t_odata;
    sync_hdr_t t_ihdr, t_ohdr;
    logic r_ovalid, r_iready, r_ohvalid, r_seed, r_primed;
    logic [31:0] r_odata;
    sync_hdr_t r_ohdr;
    // bypass
    logic b_ivalid, b_oready, b_ihvalid, b_ovalid, b_iready, b_ohvalid, b_seed, b_primed;
    logic [31:0] b_idata, b_odata;
    sync_hdr_t b_ihdr, b_ohdr;

    pcs_scrambler_ss #(.DATA_WIDTH(32), .DESCRAMBLE(1'b0), .SCRAMBLER_BYPASS(1'b0),
                       .LFSR_SEED(SEED_ONES)) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_data_valid(d_ivalid), .o_data_ready(d_oready), .i_data(d_idata),
        .i_hdr(d_ihdr), .i_hdr_valid(d_ihvalid),
        .o_data_valid(d_ovalid), .i_data_ready(d_iready), .o_data(d_odata),
        .o_hdr(d_ohdr), .o_hdr_valid(d_ohvalid),
        .i_seed_load(d_seed), .o_primed(d_primed));

    pcs_scrambler_ss #(.DATA_WIDTH(32), .DESCRAMBLE(1'b0), .SCRAMBLER_BYPASS(1'b0),
                       .LFSR_SEED(SEED_ONES)) tx2 (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_data_valid(t_ivalid), .o_data_ready(t_oready), .i_data(t_idata),
        .i_hdr(t_ihdr), .i_hdr_valid(t_ihvalid),
        .o_data_valid(t_ovalid), .i_data_ready(t_iready), .o_data(t_odata),
        .o_hdr(t_ohdr), .o_hdr_valid(t_ohvalid),
        .i_seed_load(t_seed), .o_primed(t_primed));

    pcs_scrambler_ss #(.DATA_WIDTH(32), .DESCRAMBLE(1'b1), .SCRAMBLER_BYPASS(1'b0),
                       .LFSR_SEED(58'h0)) rx (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_data_valid(t_ovalid), .o_data_ready(t_iready), .i_data(t_odata),
        .i_hdr(t_ohdr), .i_hdr_valid(t_ohvalid),
        .o_data_valid(r_ovalid), .i_data_ready(r_iready), .o_data(r_odata),
        .o_hdr(r_ohdr), .o_hdr_valid(r_ohvalid),
        .i_seed_load(r_seed), .o_primed(r_primed));

    pcs_scrambler_ss #(.DATA_WIDTH(32), .DESCRAMBLE(1'b0), .SCRAMBLER_BYPASS(1'b1),
                       .LFSR_SEED(SEED_ONES)) byp (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_data_valid(b_ivalid), .o_data_ready(b_oready), .i_data(b_idata),
        .i_hdr(b_ihdr), .i_hdr_valid(b_ihvalid),
        .o_data_valid(b_ovalid), .i_data_ready(b_iready), .o_data(b_odata),
        .o_hdr(b_ohdr), .o_hdr_valid(b_ohvalid),
        .i_seed_load(b_seed), .o_primed(b_primed));

    // ---------------- reference model: line-bit history ----------------
    // hist[0] is the oldest line bit, hist[$] the most recent one.
    bit hist[$];

    task automatic model_seed(input lfsr_t s);
        hist.delete();
        for (int k = 57; k >= 0; k--) hist.push_back(s[k]);
    endtask

    task automatic model_beat(input logic [31:0] d, output logic [31:0] y);
        bit b;
        for (int k = 0; k < 32; k++) begin
            b = d[k] ^ hist[hist.size()-39] ^ hist[hist.size()-58];
            y[k] = b;
            hist.push_back(b);
            void'(hist.pop_front());
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({d_ovalid, d_ohvalid, d_primed, r_primed} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 0000", {d_ovalid, d_ohvalid, d_primed, r_primed});
        end
        n_tests++;
        if (d_odata !== 32'h0 || d_ohdr !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_data: got %h/%b expected 0/00", d_odata, d_ohdr);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_seed(SEED_ONES);
        n_tests++;
        if (d_primed !== 1'b1) begin
            n_fail++;
            $display("FAIL primed_tx: got %b expected 1", d_primed);
        end
        n_tests++;
        if (r_primed !== 1'b0) begin
            n_fail++;
            $display("FAIL primed_rx_idle: got %b expected 0", r_primed);
        end
        $display("[TB] reset done");
    endtask

    task automatic test_zero_beat();
        logic [31:0] e;
        d_ivalid = 1'b1; d_idata = 32'h0; d_ihdr = HDR_DATA; d_ihvalid = 1'b1; d_iready = 1'b1;
        model_beat(32'h0, e);
        tick();
        d_ivalid = 1'b0;
        n_tests++;
        if (d_ovalid !== 1'b1 || d_odata !== 32'h0000_0000 || d_ohdr !== HDR_DATA) begin
            n_fail++;
            $display("FAIL zero_beat: got v=%b d=%h h=%b expected v=1 d=00000000 h=01", d_ovalid, d_odata, d_ohdr);
        end
        n_tests++;
        if (d_odata !== e) begin
            n_fail++;
            $display("FAIL zero_beat_model: got %h expected %h", d_odata, e);
        end
        tick();
        n_tests++;
        if (d_ovalid !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_beat_drop: got %b expected 0", d_ovalid);
        end
        $display("[TB] zero beat out=%h", e);
    endtask

    task automatic test_random();
        logic [31:0] exp_d_q[$];
        sync_hdr_t   exp_h_q[$];
        logic        exp_hv_q[$];
        logic [31:0] e, ed;
        sync_hdr_t   eh;
        logic        ehv;
        int sent = 0;
        int recv = 0;
        for (int cyc = 0; cyc < 6000 && (sent < 1000 || exp_d_q.size() != 0); cyc++) begin
            tick();
            d_ivalid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
            d_idata   = $urandom;
            d_ihdr    = 2'($urandom_range(0, 3));
            d_ihvalid = 1'($urandom_range(0, 1));
            d_iready  = (sent >= 1000) || ($urandom_range(0, 3) != 0);
            #1;
            if (d_ovalid && d_iready) begin
                n_tests++;
                if (exp_d_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_extra_beat: got %h expected no beat", d_odata);
                end else begin
                    ed = exp_d_q.pop_front(); eh = exp_h_q.pop_front(); ehv = exp_hv_q.pop_front();
                    if (d_odata !== ed || d_ohdr !== eh || d_ohvalid !== ehv) begin
                        n_fail++;
                        $display("FAIL rand_beat %0d: got %h/%b/%b expected %h/%b/%b",
                                 recv, d_odata, d_ohdr, d_ohvalid, ed, eh, ehv);
                    end
                end
                recv++;
            end
            if (d_ivalid && d_oready) begin
                model_beat(d_idata, e);
                exp_d_q.push_back(e); exp_h_q.push_back(d_ihdr); exp_hv_q.push_back(d_ihvalid);
                sent++;
            end
        end
        tick();
        d_ivalid = 1'b0;
        d_iready = 1'b1;
        n_tests++;
        if (sent != 1000 || recv != 1000 || exp_d_q.size() != 0) begin
            n_fail++;
            $display("FAIL rand_count: got sent=%0d recv=%0d expected 1000/1000", sent, recv);
        end
        tick();
        $display("[TB] random: %0d beats sent, %0d received", sent, recv);
    endtask

    task automatic test_backpressure();
        logic [31:0] a, b, ea, eb;
        a = $urandom; b = $urandom;
        d_ivalid = 1'b1; d_idata = a; d_ihdr = HDR_CTRL; d_ihvalid = 1'b1; d_iready = 1'b0;
        model_beat(a, ea);
        tick();
        d_idata = b; d_ihdr = HDR_DATA; d_ihvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_tests++;
            if (d_ovalid !== 1'b1 || d_odata !== ea || d_ohdr !== HDR_CTRL || d_oready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall %0d: got v=%b d=%h h=%b rdy=%b expected v=1 d=%h h=10 rdy=0",
                         i, d_ovalid, d_odata, d_ohdr, d_oready, ea);
            end
            tick();
        end
        d_iready = 1'b1;
        model_beat(b, eb);
        tick();
        d_ivalid = 1'b0;
        n_tests++;
        if (d_ovalid !== 1'b1 || d_odata !== eb || d_ohdr !== HDR_DATA || d_ohvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_resume: got v=%b d=%h h=%b expected v=1 d=%h h=01", d_ovalid, d_odata, d_ohdr, eb);
        end
        tick();
        $display("[TB] backpressure A=%h B=%h", ea, eb);
    endtask

    task automatic test_bypass();
        b_ivalid = 1'b1; b_idata = 32'hDEAD_BEEF; b_ihdr = 2'b10; b_ihvalid = 1'b1; b_iready = 1'b1;
        tick();
        b_ivalid = 1'b0;
        n_tests++;
        if (b_ovalid !== 1'b1 || b_odata !== 32'hDEAD_BEEF || b_ohdr !== 2'b10 || b_ohvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL bypass: got v=%b d=%h h=%b hv=%b expected v=1 d=deadbeef h=10 hv=1",
                     b_ovalid, b_odata, b_ohdr, b_ohvalid);
        end
        tick();
        $display("[TB] bypass out=%h", b_odata);
    endtask

    task automatic test_chain();
        logic [31:0] sent_d[$];
        sync_hdr_t   sent_h[$];
        int got = 0;
        r_iready = 1'b1;
        for (int cyc = 0; cyc < 500 && got < 20; cyc++) begin
            tick();
            t_ivalid  = (sent_d.size() < 20) && ($urandom_range(0, 2) != 0);
            t_idata   = $urandom;
            t_ihdr    = ($urandom_range(0, 1) != 0) ? HDR_DATA : HDR_CTRL;
            t_ihvalid = 1'b1;
            #1;
            if (r_ovalid && r_iready) begin
                n_tests++;
                if (r_primed !== (got >= 1) || r_ohdr !== sent_h[got]) begin
                    n_fail++;
                    $display("FAIL chain_primed_hdr %0d: got p=%b h=%b expected p=%b h=%b",
                             got, r_primed, r_ohdr, (got >= 1), sent_h[got]);
                end
                if (got >= 2) begin
                    n_tests++;
                    if (r_odata !== sent_d[got]) begin
                        n_fail++;
                        $display("FAIL chain_data %0d: got %h expected %h", got, r_odata, sent_d[got]);
                    end
                end
                got++;
            end
            if (t_ivalid && t_oready) begin
                sent_d.push_back(t_idata);
                sent_h.push_back(t_ihdr);
            end
        end
        tick();
        t_ivalid = 1'b0;
        n_tests++;
        if (got != 20) begin
            n_fail++;
            $display("FAIL chain_timeout: got %0d beats expected 20", got);
        end
        repeat (3) tick();
        $display("[TB] chain: %0d beats descrambled", got);
    endtask

    task automatic test_seed_reset();
        logic [31:0] c, e;
        // descrambler seed load alone drops o_primed
        n_tests++;
        if (r_primed !== 1'b1) begin
            n_fail++;
            $display("FAIL rx_primed_before_seed: got %b expected 1", r_primed);
        end
        r_seed = 1'b1;
        tick();
        r_seed = 1'b0;
        n_tests++;
        if (r_primed !== 1'b0) begin
            n_fail++;
            $display("FAIL rx_seed_drop: got %b expected 0", r_primed);
        end
        // seed load concurrent with a transfer counts that beat
        t_ivalid = 1'b1; t_idata = $urandom;
        tick();
        t_ivalid = 1'b0; r_seed = 1'b1;
        tick();
        r_seed = 1'b0;
        n_tests++;
        if (r_primed !== 1'b0) begin
            n_fail++;
            $display("FAIL rx_seed_xfer_cnt1: got %b expected 0", r_primed);
        end
        t_ivalid = 1'b1; t_idata = $urandom;
        tick();
        t_ivalid = 1'b0;
        tick();
        n_tests++;
        if (r_primed !== 1'b1) begin
            n_fail++;
            $display("FAIL rx_seed_xfer_cnt2: got %b expected 1", r_primed);
        end

        // seed load during a transfer on the scrambler
        d_iready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d_ivalid = 1'b1; d_idata = $urandom;
            model_beat(d_idata, e);
            tick();
        end
        c = $urandom;
        d_idata = c; d_seed = 1'b1;
        model_seed(SEED_ONES);
        model_beat(c, e);
        tick();
        d_seed = 1'b0;
        n_tests++;
        if (d_odata !== e) begin
            n_fail++;
            $display("FAIL seed_xfer: got %h expected %h", d_odata, e);
        end
        c = $urandom;
        d_idata = c;
        model_beat(c, e);
        tick();
        d_ivalid = 1'b0;
        n_tests++;
        if (d_odata !== e) begin
            n_fail++;
            $display("FAIL seed_post_beat: got %h expected %h", d_odata, e);
        end

        // asynchronous reset with a held beat
        d_ivalid = 1'b1; d_idata = $urandom; d_iready = 1'b0;
        tick();
        d_ivalid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({d_ovalid, d_primed, r_primed} !== 3'b000 || d_odata !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b p=%b rp=%b d=%h expected 0/0/0/0",
                     d_ovalid, d_primed, r_primed, d_odata);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        model_seed(SEED_ONES);
        tick();
        d_iready = 1'b1;
        n_tests++;
        if (d_ovalid !== 1'b0 || d_primed !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset: got v=%b p=%b expected v=0 p=1", d_ovalid, d_primed);
        end
        c = $urandom;
        d_ivalid = 1'b1; d_idata = c;
        model_beat(c, e);
        tick();
        d_ivalid = 1'b0;
        n_tests++;
        if (d_ovalid !== 1'b1 || d_odata !== e) begin
            n_fail++;
            $display("FAIL post_reset_beat: got v=%b d=%h expected v=1 d=%h", d_ovalid, d_odata, e);
        end
        tick();
        $display("[TB] seed load and reset done");
    endtask

    initial begin
        rst_n = 1'b0;
        d_ivalid = 1'b0; d_idata = '0; d_ihdr = '0; d_ihvalid = 1'b0; d_iready = 1'b1; d_seed = 1'b0;
        t_ivalid = 1'b0; t_idata = '0; t_ihdr = '0; t_ihvalid = 1'b0; t_seed = 1'b0;
        r_iready = 1'b1; r_seed = 1'b0;
        b_ivalid = 1'b0; b_idata = '0; b_ihdr = '0; b_ihvalid = 1'b0; b_iready = 1'b1; b_seed = 1'b0;
        test_reset();
        test_zero_beat();
        test_random();
        test_backpressure();
        test_bypass();
        test_chain();
        test_seed_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
